// File: rtl/rv32_pkg.sv
// rv32_pkg: shared opcodes, FSM states, ALU ops and select encodings for the RV32I control unit
package rv32_pkg;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;
  typedef enum logic [3:0] {
    S_FETCH, S_FETCH_WAIT, S_DECODE, S_EXECUTE, S_MEM_RD, S_MEM_WAIT, S_MEM_WR, S_WB, S_HALT
  } state_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;
  function automatic logic legal_op(input logic [31:0] ir);
    logic [2:0] f3;
    f3 = ir[14:12];
    case (ir[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OP, OP_OPIMM, OP_SYSTEM: return 1'b1;
      OP_LOAD:   return f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7;
      OP_STORE:  return f3 <= 3'd2;
      OP_BRANCH: return f3 != 3'd2 && f3 != 3'd3;
      default:   return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/rv_imm_gen.sv
// rv_imm_gen: sign-extended immediate for the I/S/B/U/J instruction formats
module rv_imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] ir,
  output logic [31:0] imm
);
  logic [6:0] op;
  assign op = ir[6:0];
  // format chosen by opcode; I-type is the fallback
  always_comb
    imm = op == OP_STORE ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
          op == OP_BRANCH ? {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} :
          (op == OP_LUI || op == OP_AUIPC) ? {ir[31:12], 12'd0} :
          op == OP_JAL ? {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0} :
          {{20{ir[31]}}, ir[31:20]};
endmodule

// File: rtl/rv_control_fsm.sv
// rv_control_fsm: multi-cycle RV32I control unit sequencing fetch, decode, execute, memory and write-back
module rv_control_fsm
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_IR = NOP,
  parameter bit HALT_ON_SYSTEM = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_rdata,
  input  logic        br_taken,
  output logic [31:0] ir_q,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        rf_w_en,
  output logic [1:0]  wb_sel,
  output logic [3:0]  alu_op,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [31:0] imm,
  output logic [2:0]  funct3,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        mem_addr_sel,
  output logic        mem_re,
  output logic        mem_we,
  output logic        halt
);
  state_t state, state_n;
  alu_op_t op_sel;
  logic [6:0] opcode;
  logic alt;
  assign opcode = ir_q[6:0];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign rd = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign halt = state == S_HALT;
  assign alu_op = op_sel;
  assign alt = ir_q[30] && (opcode == OP_OP || (opcode == OP_OPIMM && funct3 == 3'd5));
  rv_imm_gen u_imm (.ir(ir_q), .imm(imm));
  // state register; the instruction is latched as the fetch read data arrives
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_FETCH;
      ir_q <= RESET_IR;
    end else begin
      state <= state_n;
      if (state == S_FETCH_WAIT) ir_q <= mem_rdata;
    end
  // next-state sequencing by instruction class
  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:      state_n = S_FETCH_WAIT;
      S_FETCH_WAIT: state_n = S_DECODE;
      S_DECODE:     state_n = (!legal_op(ir_q) || (opcode == OP_SYSTEM && HALT_ON_SYSTEM)) ? S_HALT : S_EXECUTE;
      S_EXECUTE:    state_n = opcode == OP_LOAD ? S_MEM_RD : opcode == OP_STORE ? S_MEM_WR :
                              opcode == OP_BRANCH ? S_FETCH : S_WB;
      S_MEM_RD:     state_n = S_MEM_WAIT;
      S_MEM_WAIT:   state_n = S_WB;
      S_MEM_WR:     state_n = S_FETCH;
      S_WB:         state_n = S_FETCH;
      S_HALT:       state_n = S_HALT;
      default:      state_n = S_FETCH;
    endcase
  end
  // strobes gated off during reset; selects decoded from state and ir_q
  always_comb begin
    mem_re = !reset && (state == S_FETCH || state == S_MEM_RD);
    mem_we = !reset && state == S_MEM_WR;
    rf_w_en = !reset && state == S_WB && opcode != OP_SYSTEM;
    pc_we = !reset && (state == S_WB || state == S_MEM_WR || (state == S_EXECUTE && opcode == OP_BRANCH));
    mem_addr_sel = state == S_MEM_RD || state == S_MEM_WR;
    pc_sel = (state == S_EXECUTE && opcode == OP_BRANCH && br_taken) ? PC_IMM :
             (state == S_WB && opcode == OP_JAL) ? PC_IMM :
             (state == S_WB && opcode == OP_JALR) ? PC_ALU : PC_PLUS4;
    wb_sel = opcode == OP_LOAD ? WB_MEM : (opcode == OP_JAL || opcode == OP_JALR) ? WB_PC4 :
             opcode == OP_LUI ? WB_IMM : WB_ALU;
    alu_a_sel = opcode == OP_AUIPC;
    alu_b_sel = opcode == OP_OPIMM || opcode == OP_LOAD || opcode == OP_STORE ||
                opcode == OP_JALR || opcode == OP_AUIPC;
  end
  // ALU function: register/immediate arithmetic by funct3, address/add otherwise
  always_comb begin
    op_sel = ALU_ADD;
    if (opcode == OP_OP || opcode == OP_OPIMM)
      case (funct3)
        3'd0: op_sel = alt ? ALU_SUB : ALU_ADD;
        3'd1: op_sel = ALU_SLL;
        3'd2: op_sel = ALU_SLT;
        3'd3: op_sel = ALU_SLTU;
        3'd4: op_sel = ALU_XOR;
        3'd5: op_sel = alt ? ALU_SRA : ALU_SRL;
        3'd6: op_sel = ALU_OR;
        default: op_sel = ALU_AND;
      endcase
  end
endmodule
